fp_norm_round_pack: RTL and testbench

Back end of the FPU adder/subtractor. It is the packing direction of the unpack/align front end.
- Takes the 37-bit internal result {sign, 8-bit exponent, 28-bit extended mantissa} from the mantissa add/sub stage.
- Normalizes it iteratively (one bit per cycle), rounds to nearest-even, and packs an IEEE-754 single.
- valid/ready handshake on both sides; non-pipelined, one operation in flight.

---
 rtl/fp_norm_round_pack.sv | 174 +++++++++++++++++
 tb/tb_fp_norm_round_pack.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round_pack.sv
// Normalize / round-to-nearest-even / pack back end of the single-precision
// adder. One operation in flight; the mantissa is normalized one bit per cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand word
// NORM  | one normalization step per cycle (right shift, left shift, flush)
// ROUND | round to nearest-even, detect overflow, register packed result
// DONE  | result held on out_data until the consumer takes it
module fp_norm_round_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W+5:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_data,
    output logic                      out_ovf,
    output logic                      out_unf,
    output logic                      out_inexact
);
    localparam int MAN_W = FRAC_W + 5;
    localparam int EW    = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_ALL1  = '1;
    localparam logic [EW-1:0]    EXP_LIMIT = {1'b0, EXP_ALL1};

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  s_q, s_d;
    logic [EW-1:0]         e_q, e_d;
    logic [MAN_W-1:0]      m_q, m_d;
    logic                  zero_q, zero_d;
    logic                  flush_q, flush_d;
    logic                  spec_q, spec_d;
    logic                  out_valid_q, out_valid_d;
    logic [EXP_W+FRAC_W:0] out_data_q, out_data_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  inexact_q, inexact_d;

    logic                  round_up;
    logic                  grs_nz;
    logic [FRAC_W+1:0]     rnd_sum;
    logic [EW-1:0]         rnd_e;
    logic [FRAC_W-1:0]     rnd_frac;

    // Round-to-nearest-even on the current mantissa; a carry out of the
    // hidden bit renormalizes by one and bumps the exponent.
    assign grs_nz   = |m_q[2:0];
    assign round_up = m_q[2] & (m_q[3] | m_q[1] | m_q[0]);
    assign rnd_sum  = {1'b0, m_q[MAN_W-2:3]} + {{(FRAC_W+1){1'b0}}, round_up};
    assign rnd_e    = rnd_sum[FRAC_W+1] ? e_q + {{(EW-1){1'b0}}, 1'b1} : e_q;
    assign rnd_frac = rnd_sum[FRAC_W+1] ? rnd_sum[FRAC_W:1] : rnd_sum[FRAC_W-1:0];

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            s_q         <= 1'b0;
            e_q         <= '0;
            m_q         <= '0;
            zero_q      <= 1'b0;
            flush_q     <= 1'b0;
            spec_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e_q         <= e_d;
            m_q         <= m_d;
            zero_q      <= zero_d;
            flush_q     <= flush_d;
            spec_q      <= spec_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inexact_q   <= inexact_d;
        end
    end

    // Next-state, normalization step, and result packing.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        e_d         = e_q;
        m_d         = m_q;
        zero_d      = zero_q;
        flush_d     = flush_q;
        spec_d      = spec_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inexact_d   = inexact_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    s_d     = in_data[EXP_W+MAN_W];
                    e_d     = {1'b0, in_data[EXP_W+MAN_W-1:MAN_W]};
                    m_d     = in_data[MAN_W-1:0];
                    zero_d  = 1'b0;
                    flush_d = 1'b0;
                    spec_d  = (in_data[EXP_W+MAN_W-1:MAN_W] == EXP_ALL1);
                    state_d = (in_data[EXP_W+MAN_W-1:MAN_W] == EXP_ALL1) ? S_ROUND : S_NORM;
                end
            end
            S_NORM: begin
                if (m_q[MAN_W-1]) begin
                    // Right shift keeps the sticky bit. Staying in NORM costs one
                    // cycle so the right shift counts as a normalization step.
                    m_d = {1'b0, m_q[MAN_W-1:2], m_q[1] | m_q[0]};
                    e_d = e_q + {{(EW-1){1'b0}}, 1'b1};
                end else if (m_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = S_ROUND;
                end else if (!m_q[MAN_W-2] && (e_q != '0)) begin
                    m_d = m_q << 1;
                    e_d = e_q - {{(EW-1){1'b0}}, 1'b1};
                end else if (!m_q[MAN_W-2]) begin
                    flush_d = 1'b1;
                    state_d = S_ROUND;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                out_valid_d = 1'b1;
                state_d     = S_DONE;
                ovf_d       = 1'b0;
                unf_d       = 1'b0;
                inexact_d   = 1'b0;
                if (spec_q) begin
                    out_data_d = {s_q, EXP_ALL1, m_q[MAN_W-3:3]};
                end else if (zero_q || flush_q) begin
                    out_data_d = {s_q, {(EXP_W+FRAC_W){1'b0}}};
                    unf_d      = flush_q;
                    inexact_d  = grs_nz;
                end else if (rnd_e >= EXP_LIMIT) begin
                    out_data_d = {s_q, EXP_ALL1, {FRAC_W{1'b0}}};
                    ovf_d      = 1'b1;
                    inexact_d  = 1'b1;
                end else begin
                    out_data_d = {s_q, rnd_e[EXP_W-1:0], rnd_frac};
                    inexact_d  = grs_nz;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_inexact = inexact_q;
endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Directed bench for fp_norm_round_pack: a value-level model of the
// normalize/round/pack rules predicts every result, a negedge monitor compares.
`timescale 1ns/1ps
module tb_fp_norm_round_pack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [36:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_ovf, out_unf, out_inexact;

    always #5 clk = ~clk;

    fp_norm_round_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
    );

    typedef struct {
        logic [31:0] data;
        bit ovf, unf, inx;
        int lat;
        int acc;
    } exp_t;

    typedef struct {
        logic [36:0] vec;
        logic [31:0] data;
        bit ovf, unf, inx;
        int lat;
    } vec_t;

    exp_t exp_q[$];
    exp_t ex_mon;
    int   n_cmp = 0;
    int   n_err = 0;
    int   edges = 0;
    bit   busy = 1'b0;
    bit   seen = 1'b0;
    logic [34:0] held;
    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Value-level model: find the leading one, shift it to the hidden position
    // (bounded by the exponent), round the 24-bit significand with integer math.
    function automatic exp_t model(input logic [36:0] d);
        exp_t r;
        bit s;
        int e, p, k;
        logic [27:0] mm;
        int unsigned sum;
        bit up;
        s = d[36];
        e = int'(d[35:28]);
        mm = d[27:0];
        r.ovf = 0; r.unf = 0; r.inx = 0; r.acc = 0;
        if (e == 255) begin
            r.data = {s, 8'hFF, mm[25:3]};
            r.lat = 1;
            return r;
        end
        if (mm == 0) begin
            r.data = {s, 31'd0};
            r.lat = 2;
            return r;
        end
        if (mm[27]) begin
            mm = (mm >> 1) | {27'd0, mm[0]};
            e = e + 1;
            r.lat = 3;
        end else begin
            p = 0;
            for (int i = 0; i < 27; i++) if (mm[i]) p = i;
            k = 26 - p;
            if (k > e) begin
                mm = mm << e;
                r.data = {s, 31'd0};
                r.unf = 1;
                r.inx = |mm[2:0];
                r.lat = e + 2;
                return r;
            end
            mm = mm << k;
            e = e - k;
            r.lat = k + 2;
        end
        up = mm[2] & (mm[3] | mm[1] | mm[0]);
        r.inx = |mm[2:0];
        sum = int'(mm[26:3]) + int'(up);
        if (sum >= (1 << 24)) begin
            sum = sum >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            r.data = {s, 8'hFF, 23'd0};
            r.ovf = 1;
            r.inx = 1;
        end else begin
            r.data = {s, e[7:0], sum[22:0]};
        end
        return r;
    endfunction

    always @(posedge clk) edges++;

    // Compare process: handshake/occupancy tracking and per-cycle output checks.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy = 1'b0;
            seen = 1'b0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(!busy));
            if (!busy) begin
                check("out_valid_idle", 64'(out_valid), 64'd0);
            end else if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        fail_now("result_unexpected");
                    end else begin
                        ex_mon = exp_q.pop_front();
                        check("out_data", 64'(out_data), 64'(ex_mon.data));
                        check("out_ovf", 64'(out_ovf), 64'(ex_mon.ovf));
                        check("out_unf", 64'(out_unf), 64'(ex_mon.unf));
                        check("out_inexact", 64'(out_inexact), 64'(ex_mon.inx));
                        check("latency", 64'(edges - ex_mon.acc), 64'(ex_mon.lat));
                    end
                    seen = 1'b1;
                    held = {out_data, out_ovf, out_unf, out_inexact};
                end else begin
                    check("hold_stable", 64'({out_data, out_ovf, out_unf, out_inexact}), 64'(held));
                end
                if (out_ready) begin
                    busy = 1'b0;
                    seen = 1'b0;
                end
            end
            if (in_valid && in_ready) begin
                ex_mon = model(in_data);
                ex_mon.acc = edges + 1;
                exp_q.push_back(ex_mon);
                busy = 1'b1;
            end
        end
    end

    task automatic send(input logic [36:0] d);
        bit ok = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("result_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t m;
        bit ok;
        tbl[0]  = '{{1'b0, 8'd127, 28'h4000000}, 32'h3F800000, 0, 0, 0, 2};
        tbl[1]  = '{{1'b0, 8'd127, 28'h8000000}, 32'h40000000, 0, 0, 0, 3};
        tbl[2]  = '{{1'b0, 8'd127, 28'h0800000}, 32'h3E000000, 0, 0, 0, 5};
        tbl[3]  = '{{1'b0, 8'd127, 28'h4000004}, 32'h3F800000, 0, 0, 1, 2};
        tbl[4]  = '{{1'b0, 8'd127, 28'h400000C}, 32'h3F800002, 0, 0, 1, 2};
        tbl[5]  = '{{1'b0, 8'd254, 28'h7FFFFFC}, 32'h7F800000, 1, 0, 1, 2};
        tbl[6]  = '{{1'b1, 8'd100, 28'h0000000}, 32'h80000000, 0, 0, 0, 2};
        tbl[7]  = '{{1'b0, 8'd2,   28'h0800000}, 32'h00000000, 0, 1, 0, 4};
        tbl[8]  = '{{1'b1, 8'hFF,  28'h4000008}, 32'hFF800001, 0, 0, 0, 1};
        tbl[9]  = '{{1'b0, 8'd127, 28'h8000003}, 32'h40000000, 0, 0, 1, 3};
        tbl[10] = '{{1'b0, 8'd0,   28'h1000000}, 32'h00000000, 0, 1, 0, 2};
        tbl[11] = '{{1'b1, 8'd130, 28'h0000014}, 32'hB6200000, 0, 0, 0, 24};

        // Reset state, sampled after a reset edge with rst still high.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_flags", 64'({out_ovf, out_unf, out_inexact}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pin the model to hand-computed results.
        for (int i = 0; i < 12; i++) begin
            m = model(tbl[i].vec);
            check($sformatf("model_data[%0d]", i), 64'(m.data), 64'(tbl[i].data));
            check($sformatf("model_flags[%0d]", i), 64'({m.ovf, m.unf, m.inx}),
                  64'({tbl[i].ovf, tbl[i].unf, tbl[i].inx}));
            check($sformatf("model_lat[%0d]", i), 64'(m.lat), 64'(tbl[i].lat));
        end

        // Directed vectors through the DUT.
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].vec);
            wait_idle();
        end

        // Backpressure: result held, busy input ignored.
        out_ready = 1'b0;
        send({1'b1, 8'd100, 28'h0});
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("bp_out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 in_valid = 1'b1;
            in_data = {1'b0, 8'd127, 28'h4000000};
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'h80000000);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset while normalizing discards the operation.
        send({1'b0, 8'd127, 28'h0800000});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;

        // Recovery after reset.
        send(tbl[4].vec);
        wait_idle();

        repeat (3) @(posedge clk);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
